// File: rtl/onedconv_pkg.sv
// Shared types and sizing for the 1-D convolution buffer loader.
package onedconv_pkg;

   // Sequencer phases
   typedef enum logic [1:0] {IDLE, WLOAD, ILOAD, DRAIN} state_t;

   // Largest supported array size; counters are sized for it
   localparam int unsigned DIMENSION_MAX = 16;
   localparam int unsigned SLOTS         = DIMENSION_MAX + 1;
   localparam int unsigned CNT_W         = $clog2(SLOTS);

endpackage

// File: rtl/onedconv_addr_gen.sv
// Address generator: latches the bases at accept, accumulates the ifmap row
// offset by addition and registers the BRAM read requests.
module onedconv_addr_gen
   import onedconv_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] ifmap_base_addr,
   input  logic [ADDR_W-1:0] row_stride,
   input  logic [ADDR_W-1:0] weight_base_addr,
   input  logic              step_row,
   input  logic              rd_weight,
   input  logic              rd_ifmap,
   input  logic [CNT_W-1:0]  offs,
   output logic              weight_bram_en,
   output logic [ADDR_W-1:0] weight_bram_addr,
   output logic              ifmap_bram_en,
   output logic [ADDR_W-1:0] ifmap_bram_addr
);

   logic [ADDR_W-1:0] ibase_q;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] wbase_q;
   logic [ADDR_W-1:0] row_off_q;
   logic [ADDR_W-1:0] row_off_nxt;
   logic [ADDR_W-1:0] wbase_cur;
   logic [ADDR_W-1:0] offs_ext;

   // Row offset for the slot being issued; weight base bypasses the latch on accept
   always_comb begin
      row_off_nxt = row_off_q;
      if (load) begin
         row_off_nxt = '0;
      end else if (step_row) begin
         row_off_nxt = row_off_q + stride_q;
      end
      wbase_cur = load ? weight_base_addr : wbase_q;
      offs_ext  = ADDR_W'(offs);
   end

   // Base latch, offset accumulator and registered read requests
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ibase_q          <= '0;
         stride_q         <= '0;
         wbase_q          <= '0;
         row_off_q        <= '0;
         weight_bram_en   <= 1'b0;
         weight_bram_addr <= '0;
         ifmap_bram_en    <= 1'b0;
         ifmap_bram_addr  <= '0;
      end else begin
         if (load) begin
            ibase_q  <= ifmap_base_addr;
            stride_q <= row_stride;
            wbase_q  <= weight_base_addr;
         end
         row_off_q      <= row_off_nxt;
         weight_bram_en <= rd_weight;
         ifmap_bram_en  <= rd_ifmap;
         if (rd_weight) begin
            weight_bram_addr <= wbase_cur + offs_ext;
         end
         if (rd_ifmap) begin
            ifmap_bram_addr <= ibase_q + row_off_nxt + offs_ext;
         end
      end
   end

endmodule

// File: rtl/onedconv_buffer_loader.sv
// Fills the 1-D convolution input shift-register buffers: all weight rows in
// parallel, then the ifmap rows one at a time, with a registered stage that
// aligns shift enables and zero/data selects with the BRAM read data.
// Optional feature macro: ONEDCONV_LOADER_PAD_EN (slot 0 of each row pushes a zero).
module onedconv_buffer_loader
   import onedconv_pkg::*;
#(
   parameter int unsigned DW        = 16,
   parameter int unsigned Dimension = DIMENSION_MAX,
   parameter int unsigned ADDR_W    = 10
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_W-1:0]    ifmap_base_addr,
   input  logic [ADDR_W-1:0]    row_stride,
   input  logic [ADDR_W-1:0]    weight_base_addr,
   output logic                 weight_bram_en,
   output logic [ADDR_W-1:0]    weight_bram_addr,
   output logic                 ifmap_bram_en,
   output logic [ADDR_W-1:0]    ifmap_bram_addr,
   output logic [Dimension-1:0] en_shift_reg_weight_muxed,
   output logic [Dimension-1:0] en_shift_reg_ifmap_muxed,
   output logic                 zero_or_data_weight,
   output logic                 zero_or_data,
   output logic                 busy,
   output logic                 done
);

   if (DW == 0 || Dimension == 0 || Dimension + 1 > SLOTS) begin : g_bad_cfg
      $error("onedconv_buffer_loader: unsupported DW/Dimension");
   end

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      k, k_nxt;
   logic [CNT_W-1:0]      r, r_nxt;
   logic                  kill, load, step_row, pad_nxt;
   logic                  rd_weight, rd_ifmap;
   logic [CNT_W-1:0]      offs_nxt;
   logic                  s1_weight, s1_weight_nxt;
   logic                  s1_ifmap, s1_ifmap_nxt;
   logic                  s1_pad, s1_pad_nxt;
   logic [Dimension-1:0]  s1_row, s1_row_nxt;
   logic [Dimension-1:0]  enw_nxt, eni_nxt;
   logic                  zdw_nxt, zd_nxt, busy_nxt, done_nxt;

   // Next-state, slot issue and aligned-stage decode
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      r_nxt     = r;
      load      = 1'b0;
      step_row  = 1'b0;
      done_nxt  = 1'b0;
      kill      = abort && (state != IDLE);

      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = WLOAD;
               k_nxt     = '0;
               r_nxt     = '0;
               load      = 1'b1;
            end
         end
         WLOAD: begin
            if (k == CNT_W'(Dimension)) begin
               state_nxt = ILOAD;
               k_nxt     = '0;
               r_nxt     = '0;
            end else begin
               k_nxt = k + CNT_W'(1);
            end
         end
         ILOAD: begin
            if (k == CNT_W'(Dimension)) begin
               k_nxt = '0;
               if (r == CNT_W'(Dimension - 1)) begin
                  state_nxt = DRAIN;
               end else begin
                  r_nxt    = r + CNT_W'(1);
                  step_row = 1'b1;
               end
            end else begin
               k_nxt = k + CNT_W'(1);
            end
         end
         DRAIN: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      if (kill) begin
         state_nxt = IDLE;
         k_nxt     = '0;
         r_nxt     = '0;
         step_row  = 1'b0;
         done_nxt  = 1'b0;
      end

`ifdef ONEDCONV_LOADER_PAD_EN
      pad_nxt  = (k_nxt == '0);
      offs_nxt = k_nxt - CNT_W'(1);
`else
      pad_nxt  = 1'b0;
      offs_nxt = k_nxt;
`endif

      s1_weight_nxt = (state_nxt == WLOAD);
      s1_ifmap_nxt  = (state_nxt == ILOAD);
      s1_pad_nxt    = pad_nxt;
      s1_row_nxt    = s1_ifmap_nxt ? (Dimension'(1) << r_nxt) : '0;
      rd_weight     = s1_weight_nxt && !pad_nxt;
      rd_ifmap      = s1_ifmap_nxt && !pad_nxt;
      busy_nxt      = (state_nxt != IDLE);

      enw_nxt = (s1_weight && !kill) ? '1 : '0;
      eni_nxt = (s1_ifmap && !kill) ? s1_row : '0;
      zdw_nxt = s1_weight && !s1_pad && !kill;
      zd_nxt  = s1_ifmap && !s1_pad && !kill;
   end

   // State, counters, issue stage and aligned output stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                     <= IDLE;
         k                         <= '0;
         r                         <= '0;
         s1_weight                 <= 1'b0;
         s1_ifmap                  <= 1'b0;
         s1_pad                    <= 1'b0;
         s1_row                    <= '0;
         en_shift_reg_weight_muxed <= '0;
         en_shift_reg_ifmap_muxed  <= '0;
         zero_or_data_weight       <= 1'b0;
         zero_or_data              <= 1'b0;
         busy                      <= 1'b0;
         done                      <= 1'b0;
      end else begin
         state                     <= state_nxt;
         k                         <= k_nxt;
         r                         <= r_nxt;
         s1_weight                 <= s1_weight_nxt;
         s1_ifmap                  <= s1_ifmap_nxt;
         s1_pad                    <= s1_pad_nxt;
         s1_row                    <= s1_row_nxt;
         en_shift_reg_weight_muxed <= enw_nxt;
         en_shift_reg_ifmap_muxed  <= eni_nxt;
         zero_or_data_weight       <= zdw_nxt;
         zero_or_data              <= zd_nxt;
         busy                      <= busy_nxt;
         done                      <= done_nxt;
      end
   end

   onedconv_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk              (clk),
      .rst              (rst),
      .load             (load),
      .ifmap_base_addr  (ifmap_base_addr),
      .row_stride       (row_stride),
      .weight_base_addr (weight_base_addr),
      .step_row         (step_row),
      .rd_weight        (rd_weight),
      .rd_ifmap         (rd_ifmap),
      .offs             (offs_nxt),
      .weight_bram_en   (weight_bram_en),
      .weight_bram_addr (weight_bram_addr),
      .ifmap_bram_en    (ifmap_bram_en),
      .ifmap_bram_addr  (ifmap_bram_addr)
   );

endmodule

// File: tb/tb_onedconv_buffer_loader.sv
// Directed bench for onedconv_buffer_loader with Dimension=4; expectations
// follow ONEDCONV_LOADER_PAD_EN when it is defined.
module tb_onedconv_buffer_loader;

   localparam int unsigned DIM  = 4;
   localparam int unsigned AW   = 10;
   localparam int          NCYC = 34;
`ifdef ONEDCONV_LOADER_PAD_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] ifmap_base_addr = '0;
   logic [AW-1:0] row_stride = '0;
   logic [AW-1:0] weight_base_addr = '0;
   logic          weight_bram_en, ifmap_bram_en;
   logic [AW-1:0] weight_bram_addr, ifmap_bram_addr;
   logic [DIM-1:0] en_shift_reg_weight_muxed, en_shift_reg_ifmap_muxed;
   logic          zero_or_data_weight, zero_or_data, busy, done;

   always #5 clk = ~clk;

   onedconv_buffer_loader #(.DW(16), .Dimension(DIM), .ADDR_W(AW)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .start                     (start),
      .abort                     (abort),
      .ifmap_base_addr           (ifmap_base_addr),
      .row_stride                (row_stride),
      .weight_base_addr          (weight_base_addr),
      .weight_bram_en            (weight_bram_en),
      .weight_bram_addr          (weight_bram_addr),
      .ifmap_bram_en             (ifmap_bram_en),
      .ifmap_bram_addr           (ifmap_bram_addr),
      .en_shift_reg_weight_muxed (en_shift_reg_weight_muxed),
      .en_shift_reg_ifmap_muxed  (en_shift_reg_ifmap_muxed),
      .zero_or_data_weight       (zero_or_data_weight),
      .zero_or_data              (zero_or_data),
      .busy                      (busy),
      .done                      (done)
   );

   // Per-cycle capture, index = cycle number relative to the start edge
   logic           l_wen  [0:NCYC];
   logic [AW-1:0]  l_waddr[0:NCYC];
   logic           l_ien  [0:NCYC];
   logic [AW-1:0]  l_iaddr[0:NCYC];
   logic [DIM-1:0] l_enw  [0:NCYC];
   logic [DIM-1:0] l_eni  [0:NCYC];
   logic           l_zdw  [0:NCYC];
   logic           l_zd   [0:NCYC];
   logic           l_busy [0:NCYC];
   logic           l_done [0:NCYC];

   int    n_checks = 0;
   int    n_errors = 0;
   string scen = "reset";

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s/%s: got 0x%0h expected 0x%0h", scen, tag, got, exp);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({weight_bram_en, weight_bram_addr, ifmap_bram_en, ifmap_bram_addr,
                  en_shift_reg_weight_muxed, en_shift_reg_ifmap_muxed,
                  zero_or_data_weight, zero_or_data, busy, done});
   endfunction

   // One start at edge 0, optional extra start/abort/reset in given cycles
   task automatic run_seq(input logic [AW-1:0] ibase, input int start2_cyc,
                          input int abort_cyc, input int rst_cyc);
      ifmap_base_addr  = ibase;
      row_stride       = 10'd2;
      weight_base_addr = 10'h100;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= NCYC; c++) begin
         @(negedge clk);
         start = (c == start2_cyc);
         abort = (c == abort_cyc);
         l_wen[c]   = weight_bram_en;
         l_waddr[c] = weight_bram_addr;
         l_ien[c]   = ifmap_bram_en;
         l_iaddr[c] = ifmap_bram_addr;
         l_enw[c]   = en_shift_reg_weight_muxed;
         l_eni[c]   = en_shift_reg_ifmap_muxed;
         l_zdw[c]   = zero_or_data_weight;
         l_zd[c]    = zero_or_data;
         l_busy[c]  = busy;
         l_done[c]  = done;
         if (c == rst_cyc) begin
            rst = 1'b0;
            #1;
            check("async_rst_outputs", all_outputs(), 64'd0);
            @(negedge clk);
            rst = 1'b1;
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Expectations for one full unaborted sequence
   task automatic check_nominal();
      int ndone;
      int npad;
      ndone = 0;
      npad  = 0;
      if (P == 1) check("w_pad_no_read", 64'(l_wen[1]), 64'd0);
      for (int k = P; k <= int'(DIM); k++) begin
         check("w_en", 64'(l_wen[k + 1]), 64'd1);
         check("w_addr", 64'(l_waddr[k + 1]), 64'(10'h100 + k - P));
      end
      for (int c = 2; c <= 6; c++) check("enw_on", 64'(l_enw[c]), 64'hF);
      check("enw_off", 64'(l_enw[7]), 64'h0);
      check("zdw_first", 64'(l_zdw[2]), 64'(1 - P));
      check("zdw_second", 64'(l_zdw[3]), 64'd1);
      if (P == 1) check("row2_pad_no_read", 64'(l_ien[16]), 64'd0);
      for (int k = P; k <= int'(DIM); k++) begin
         check("row2_en", 64'(l_ien[16 + k]), 64'd1);
         check("row2_addr", 64'(l_iaddr[16 + k]), 64'(10'h014 + k - P));
      end
      for (int c = 17; c <= 21; c++) check("row2_eni", 64'(l_eni[c]), 64'b0100);
      check("row2_zd_first", 64'(l_zd[17]), 64'(1 - P));
      check("row2_zd_second", 64'(l_zd[18]), 64'd1);
      check("row3_last_eni", 64'(l_eni[26]), 64'b1000);
      for (int c = 1; c <= NCYC; c++) begin
         if (l_done[c]) ndone++;
         if (l_eni[c] != '0 && !l_zd[c]) npad++;
      end
      check("ifmap_zero_pushes", 64'(npad), 64'(P * DIM));
      check("done_count", 64'(ndone), 64'd1);
      check("done_c27", 64'(l_done[27]), 64'd1);
      check("busy_c1", 64'(l_busy[1]), 64'd1);
      check("busy_c26", 64'(l_busy[26]), 64'd1);
      check("busy_c27", 64'(l_busy[27]), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] wrap_exp [0:4];
      int            stray;
      wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002};

      // Reset values
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outputs(), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", all_outputs(), 64'd0);

      scen = "nominal";
      run_seq(10'h010, -1, -1, -1);
      check_nominal();

      scen = "extra_start";
      run_seq(10'h010, 10, -1, -1);
      check_nominal();

      scen = "abort";
      run_seq(10'h010, -1, 12, -1);
      check("busy_before_abort", 64'(l_busy[12]), 64'd1);
      check("abort_enw", 64'(l_enw[13]), 64'd0);
      check("abort_eni", 64'(l_eni[13]), 64'd0);
      check("abort_busy", 64'(l_busy[13]), 64'd0);
      check("abort_reads", 64'({l_wen[13], l_ien[13]}), 64'd0);
      stray = 0;
      for (int c = 13; c <= NCYC; c++) if (l_done[c] || l_busy[c]) stray++;
      check("abort_no_done_busy", 64'(stray), 64'd0);
      scen = "abort_replay";
      run_seq(10'h010, -1, -1, -1);
      check_nominal();

      scen = "mid_reset";
      run_seq(10'h010, -1, -1, 15);
      check("busy_before_rst", 64'(l_busy[15]), 64'd1);
      stray = 0;
      for (int c = 16; c <= NCYC; c++)
         if (l_busy[c] || l_done[c] || l_wen[c] || l_ien[c] || l_eni[c] != '0) stray++;
      check("idle_after_rst", 64'(stray), 64'd0);
      scen = "rst_replay";
      run_seq(10'h010, -1, -1, -1);
      check_nominal();

      scen = "addr_wrap";
      run_seq(10'h3FE, -1, -1, -1);
      for (int k = P; k <= int'(DIM); k++) begin
         check("wrap_en", 64'(l_ien[6 + k]), 64'd1);
         check("wrap_addr", 64'(l_iaddr[6 + k]), 64'(wrap_exp[k - P]));
      end
      check("wrap_done_c27", 64'(l_done[27]), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/onedconv_buffer_loader.md
# onedconv_buffer_loader

Sequencer that fills the 1-D convolution input shift-register buffers ahead of the systolic array. It reads weight BRAMs (Dimension lanes wide) and the ifmap BRAM (one word per cycle), inserts zero-padding slots, and drives the per-row shift enables and zero/data selects. One `start` loads all weight rows in parallel, then loads the ifmap rows one row at a time.

## Interface
- `DW`, 16, word width
- `Dimension`, 16, array rows; each buffer row holds `Dimension+1` words
- `ADDR_W`, 10, BRAM address width
- `clk`  in  1  single clock; all outputs change on the rising edge; the buffers sample on the falling edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; accepted only in IDLE
- `abort`  in  1  synchronous cancel
- `ifmap_base_addr`  in  ADDR_W  start address of ifmap row 0; latched at accept
- `row_stride`  in  ADDR_W  address offset between ifmap rows; latched at accept
- `weight_base_addr`  in  ADDR_W  first weight address; latched at accept
- `weight_bram_en` / `weight_bram_addr`  out  1 / ADDR_W  weight read request; read latency is 1 cycle
- `ifmap_bram_en` / `ifmap_bram_addr`  out  1 / ADDR_W  ifmap read request; read latency is 1 cycle
- `en_shift_reg_weight_muxed`  out  Dimension  weight row shift enables
- `en_shift_reg_ifmap_muxed`  out  Dimension  ifmap row shift enables
- `zero_or_data_weight`, `zero_or_data`  out  1  1 = pass BRAM data; 0 = push zero
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: `start` moves to WLOAD.
  - WLOAD: runs `Dimension+1` slots, then moves to ILOAD with row 0.
  - ILOAD: runs `Dimension+1` slots per row. After row `Dimension-1`, moves to DRAIN.
  - DRAIN: one cycle. Moves to IDLE and pulses `done`.
- Slot counter `k` runs 0..Dimension. Row counter `r` runs 0..Dimension-1.
- WLOAD slots:
  - Slot 0 is the pad slot: no read, zero pushed.
  - Slot k≥1 reads `weight_base_addr+k-1`.
- ILOAD slots for row r:
  - Slot 0 is the pad slot.
  - Slot k≥1 reads `ifmap_base_addr + r*row_stride + k-1`.
  - Addresses wrap modulo 2^ADDR_W. The row offset is accumulated by addition, not by a multiplier.
- Stage-2 register (aligned with BRAM data):
  - WLOAD: `en_shift_reg_weight_muxed` = all ones.
  - ILOAD: `en_shift_reg_ifmap_muxed` = one-hot bit r.
  - `zero_or_data*` = 0 in the pad slot, 1 otherwise.
- Push order: the first word pushed (the pad zero) ends at the shift-register output end.
- `start` while busy is ignored. `start` in the `done` cycle (state IDLE) is accepted.
- `abort`, in any non-IDLE state: on the next edge go to IDLE, all enables 0, `busy`=0, no `done`. Buffer contents are left undefined.
- `abort` and `start` in the same cycle: `abort` wins and `start` is dropped.

## Timing
- Reset values: every output is 0, state IDLE, counters 0. Reset is asserted asynchronously.
- Cycle numbering: `start` is sampled at edge 0.
  - Slots are issued on cycles 1..N, where N=(Dimension+1)^2.
  - Enables are valid on cycles 2..N+1, exactly one cycle after the matching address.
  - `done` is high on cycle N+2.
  - `busy` is high on cycles 1..N+1.
- Enables, selects and addresses come from registers only, so they are glitch-free for the negedge-sampling buffers.
- No bubbles between rows or between the weight and ifmap phases.

## Configuration
- `ONEDCONV_LOADER_PAD_EN`, defined:
  - Pad slot 0 as described above.
- Undefined:
  - No pad slots. Slot k reads `base+k` for k=0..Dimension.
  - `zero_or_data*` are tied to 1 while enables are active.
  - Cycle counts are unchanged.

## Structure
- `onedconv_pkg` holds:
  - the state enum {IDLE, WLOAD, ILOAD, DRAIN};
  - localparam `SLOTS = Dimension+1`;
  - the counter width `$clog2(Dimension+1)`.
- One sub-module, `onedconv_addr_gen`: base latch, row-offset accumulator and slot address adder, with registered output.

## Test plan
All scenarios use `Dimension`=4, `ifmap_base`=0x010, `row_stride`=2, `weight_base`=0x100.
1. Nominal `start`:
   - weight reads 0x100..0x103 on cycles 2..5;
   - `en_shift_reg_weight_muxed`=4'hF on cycles 2..6, with `zero_or_data_weight`=0 on cycle 2;
   - ifmap row 2 reads 0x014..0x017 with enable 4'b0100;
   - `done` high on cycle 27 only.
2. Extra `start` pulse on cycle 10 → ignored; exactly one `done`, on cycle 27.
3. `abort` on cycle 12 → cycle 13: all enables 0, `busy`=0; no `done`. A following `start` replays the full 27-cycle sequence.
4. `rst` low mid-row-1 (cycle 15) → all outputs 0 immediately. After release the block is idle and waits for `start`.
5. `ifmap_base`=0x3FE, `ADDR_W`=10 → row 0 reads 0x3FE, 0x3FF, 0x000, 0x001.
6. Macro undefined → `zero_or_data` never 0; row 0 reads 0x010..0x014 (5 reads); `done` still on cycle 27.
